hex_tx_formatter: RTL and testbench
===================================

Name: hex_tx_formatter

Overview:
Transmit-side counterpart of the UART hex display path. On a send request it captures a packed set of 5-bit hex slots (bit4 = blank, bits3:0 = nibble), converts each non-blank slot to an uppercase ASCII hex character, and streams the characters MSB-slot-first to the UART transmitter using a start/busy handshake. It optionally appends CR LF and counts completed frames for display.

Parameters:
NUM_DIGITS, 6, number of 5-bit slots in slots_in.
APPEND_CRLF, 1, 1 = send 8'h0D then 8'h0A after the last digit; 0 = no terminator.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
send_req  input  1  one-cycle request to transmit slots_in
slots_in  input  5*NUM_DIGITS  packed slots; slot NUM_DIGITS-1 in MSBs is sent first; bit4=1 marks blank
tx_busy  input  1  UART transmitter busy flag
tx_start  output  1  one-cycle pulse; tx_data valid in the same cycle
tx_data  output  8  ASCII byte to transmit
busy  output  1  high from request acceptance until frame completion
frame_done  output  1  one-cycle pulse when the last byte of a frame has completed
frame_count  output  8  number of completed frames, wraps 255 -> 0

Behaviour:
- Reset (async, rst=1): state IDLE; tx_start=0, tx_data=8'h00, busy=0, frame_done=0, frame_count=0; captured slots cleared to blank (5'h1F); index=0. Reset mid-frame aborts immediately; no further tx_start.
- Reset values are held until the first clock edge after rst deasserts.
- Encoding: nibble 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10). Blank slots are skipped: no byte and no cycle spent on the UART.
- FSM states:
  - IDLE -> LOAD when send_req=1. The edge that leaves IDLE latches slots_in, clears index, and sets busy=1. send_req in any other state is ignored; no queueing.
  - LOAD:
    - If the slot at index is blank and is not the last slot, increment index and stay in LOAD (one cycle per skipped slot).
    - If the slot is non-blank, load tx_data and go to SEND.
    - After the last slot: go to CR if APPEND_CRLF=1, else FINISH.
  - SEND: wait while tx_busy=1. When tx_busy=0, pulse tx_start for exactly one cycle and go to WAIT_ACK.
  - WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0. Then advance: next slot -> LOAD, or CR/LF/FINISH as appropriate.
  - CR / LF: load 8'h0D / 8'h0A and reuse the SEND/WAIT_ACK/WAIT_DONE sequence.
  - FINISH: one cycle. frame_done=1, frame_count increments (wrap 255->0), busy=0, then return to IDLE.
- tx_data holds the last sent byte between frames.
- Latency: send_req at edge N -> first tx_start no earlier than edge N+2, when slot 0 is non-blank and tx_busy=0.
- All slots blank:
  - APPEND_CRLF=1: only CR LF is sent.
  - APPEND_CRLF=0: no bytes are sent, FINISH is entered directly, and frame_done/frame_count still update.
- send_req arriving in the FINISH cycle is ignored. A new request is accepted only in IDLE.

Test Plan:
- Basic frame: slots_in = {1,2,3,A,B,C} all non-blank; bench UART holds busy for 10 cycles per byte. Required: tx_data sequence 31,32,33,41,42,43,0D,0A; exactly 8 tx_start pulses, each 1 cycle; frame_done once; frame_count=1.
- Blank skip: slots = {1F,1F,1F,05,1F,0F}. Required: bytes 35,46,0D,0A only.
- All blank with APPEND_CRLF=0: required: no tx_start; frame_done pulses; frame_count increments; busy high for the frame and then low.
- Handshake stall: hold tx_busy=1 before the first byte. Required: no tx_start until busy falls, then tx_start occurs on the next edge. Also: send_req pulses during the frame are ignored and frame_count increments only once.
- Wrap: run 256 frames. Required: frame_count returns to 0x00.
- Reset mid-frame: assert rst after the 2nd byte. Required: all outputs immediately at reset values; no further tx_start; a subsequent send_req starts a new frame from the MSB slot.

Source files
------------

// File: rtl/hex_tx_formatter.sv
// Streams a captured set of 5-bit hex slots to a UART as uppercase ASCII, MSB slot first,
// skipping blank slots and optionally terminating each frame with CR LF.
module hex_tx_formatter #(
  parameter int NUM_DIGITS  = 6,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    send_req,
  input  logic [5*NUM_DIGITS-1:0] slots_in,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              frame_count
);

  localparam int SW = 5 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, CR, LF, FINISH
  } state_t;

  typedef enum logic [1:0] {
    PH_DIGIT, PH_CR, PH_LF
  } phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [SW-1:0]    slots_q, slots_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [7:0]       txData_q, txData_d;
  logic             txStart_q, txStart_d;
  logic             busy_q, busy_d;
  logic             frameDone_q, frameDone_d;
  logic [7:0]       frameCount_q, frameCount_d;

  logic [4:0] curSlot;
  logic [7:0] curAscii;
  logic       lastSlot;

  // The captured slots shift left as the frame advances, so the slot being sent is always on top.
  assign curSlot  = slots_q[SW-1 -: 5];
  assign lastSlot = (index_q == LAST_IDX);
  assign curAscii = (curSlot[3:0] < 4'd10) ? (8'h30 + {4'h0, curSlot[3:0]})
                                           : (8'h37 + {4'h0, curSlot[3:0]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= PH_DIGIT;
      slots_q      <= '1;
      index_q      <= '0;
      txData_q     <= 8'h00;
      txStart_q    <= 1'b0;
      busy_q       <= 1'b0;
      frameDone_q  <= 1'b0;
      frameCount_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      slots_q      <= slots_d;
      index_q      <= index_d;
      txData_q     <= txData_d;
      txStart_q    <= txStart_d;
      busy_q       <= busy_d;
      frameDone_q  <= frameDone_d;
      frameCount_q <= frameCount_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    slots_d      = slots_q;
    index_d      = index_q;
    txData_d     = txData_q;
    txStart_d    = 1'b0;
    busy_d       = busy_q;
    frameDone_d  = 1'b0;
    frameCount_d = frameCount_q;

    case (state_q)
      IDLE: begin
        if (send_req) begin
          state_d = LOAD;
          phase_d = PH_DIGIT;
          slots_d = slots_in;
          index_d = '0;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        if (!curSlot[4]) begin
          txData_d = curAscii;
          phase_d  = PH_DIGIT;
          state_d  = SEND;
        end else if (!lastSlot) begin
          index_d = index_q + IDX_W'(1);
          slots_d = SW'({slots_q, 5'h1F});
        end else begin
          state_d = APPEND_CRLF ? CR : FINISH;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          txStart_d = 1'b1;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          case (phase_q)
            PH_DIGIT: begin
              if (lastSlot) begin
                state_d = APPEND_CRLF ? CR : FINISH;
              end else begin
                index_d = index_q + IDX_W'(1);
                slots_d = SW'({slots_q, 5'h1F});
                state_d = LOAD;
              end
            end
            PH_CR:   state_d = LF;
            default: state_d = FINISH;
          endcase
        end
      end
      CR: begin
        txData_d = 8'h0D;
        phase_d  = PH_CR;
        state_d  = SEND;
      end
      LF: begin
        txData_d = 8'h0A;
        phase_d  = PH_LF;
        state_d  = SEND;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Frame completion is registered so frame_done and the new count appear together in FINISH.
    if (state_d == FINISH && state_q != FINISH) begin
      frameDone_d  = 1'b1;
      frameCount_d = frameCount_q + 8'd1;
      busy_d       = 1'b0;
    end
  end

  assign tx_start    = txStart_q;
  assign tx_data     = txData_q;
  assign busy        = busy_q;
  assign frame_done  = frameDone_q;
  assign frame_count = frameCount_q;

endmodule

// File: tb/tb_hex_tx_formatter.sv
// Bench for hex_tx_formatter: one instance with CR LF, one without, each driven by a simple
// UART busy model and checked against a byte-list model of each frame.
module tb_hex_tx_formatter;

  localparam logic [29:0] BASIC  = {5'h01, 5'h02, 5'h03, 5'h0A, 5'h0B, 5'h0C};
  localparam logic [29:0] SKIPS  = {5'h1F, 5'h1F, 5'h1F, 5'h05, 5'h1F, 5'h0F};
  localparam logic [29:0] BLANKS = {6{5'h1F}};
  localparam logic [29:0] AFTER  = {5'h0F, 5'h1F, 5'h00, 5'h09, 5'h1F, 5'h0A};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sendReq[2]    = '{1'b0, 1'b0};
  logic [29:0] slotsIn[2]    = '{BLANKS, BLANKS};
  logic        stall[2]      = '{1'b0, 1'b0};
  logic        uartBusy[2]   = '{1'b0, 1'b0};
  logic        txBusy[2];
  logic        txStart[2];
  logic [7:0]  txData[2];
  logic        busyO[2];
  logic        frameDone[2];
  logic [7:0]  frameCount[2];

  int          busyLen[2]    = '{10, 10};
  int          busyCnt[2]    = '{0, 0};
  logic        prevStart[2]  = '{1'b0, 1'b0};
  int          protoErr[2]   = '{0, 0};
  int          capCnt[2]     = '{0, 0};
  int          doneCnt[2]    = '{0, 0};
  logic [7:0]  capMem[2][0:63];
  int          expCount[2]   = '{0, 0};

  logic [7:0]  expBytes[0:15];
  int          expLen;
  string       hexChars = "0123456789ABCDEF";
  int          nChecks = 0;
  int          nErrors = 0;
  int          c0, d0, cyc;

  always #5 clk = ~clk;

  assign txBusy[0] = uartBusy[0] | stall[0];
  assign txBusy[1] = uartBusy[1] | stall[1];

  hex_tx_formatter #(.NUM_DIGITS(6), .APPEND_CRLF(1'b1)) dut (
    .clk(clk), .rst(rst), .send_req(sendReq[0]), .slots_in(slotsIn[0]),
    .tx_busy(txBusy[0]), .tx_start(txStart[0]), .tx_data(txData[0]),
    .busy(busyO[0]), .frame_done(frameDone[0]), .frame_count(frameCount[0])
  );

  hex_tx_formatter #(.NUM_DIGITS(6), .APPEND_CRLF(1'b0)) dutNoCrlf (
    .clk(clk), .rst(rst), .send_req(sendReq[1]), .slots_in(slotsIn[1]),
    .tx_busy(txBusy[1]), .tx_start(txStart[1]), .tx_data(txData[1]),
    .busy(busyO[1]), .frame_done(frameDone[1]), .frame_count(frameCount[1])
  );

  // UART model: records each started byte, stays busy busyLen cycles, flags handshake abuse.
  always @(posedge clk or posedge rst) begin
    for (int w = 0; w < 2; w++) begin
      if (rst) begin
        uartBusy[w]  <= 1'b0;
        busyCnt[w]   = 0;
        prevStart[w] = 1'b0;
      end else begin
        if (txStart[w]) begin
          if (prevStart[w] || txBusy[w]) protoErr[w]++;
          capMem[w][capCnt[w] % 64] = txData[w];
          capCnt[w]++;
          busyCnt[w]  = busyLen[w];
          uartBusy[w] <= 1'b1;
        end else if (busyCnt[w] > 0) begin
          busyCnt[w]--;
          if (busyCnt[w] == 0) uartBusy[w] <= 1'b0;
        end
        if (frameDone[w]) doneCnt[w]++;
        prevStart[w] = txStart[w];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int w, input logic [29:0] slots);
    slotsIn[w] = slots;
    sendReq[w] = 1'b1;
    tick();
    sendReq[w] = 1'b0;
  endtask

  // Expected byte list: non-blank slots from the top as hex characters, then optional CR LF.
  task automatic modelFrame(input logic [29:0] slots, input bit crlf);
    logic [4:0] s;
    expLen = 0;
    for (int i = 5; i >= 0; i--) begin
      s = slots[i*5 +: 5];
      if (!s[4]) begin
        expBytes[expLen] = hexChars[int'(s[3:0])];
        expLen++;
      end
    end
    if (crlf) begin
      expBytes[expLen]     = 8'h0D;
      expBytes[expLen + 1] = 8'h0A;
      expLen += 2;
    end
  endtask

  function automatic logic [29:0] randSlots();
    logic [29:0] s;
    for (int i = 0; i < 6; i++)
      s[i*5 +: 5] = {($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15))};
    return s;
  endfunction

  task automatic finishFrame(input int w, input int cs, input int ds, input bit spam);
    int n = 0;
    while (doneCnt[w] == ds && n < 3000) begin
      sendReq[w] = spam && ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    sendReq[w] = 1'b0;
    checkOutput("frameDone", doneCnt[w] - ds, 1);
    checkOutput("byteCount", capCnt[w] - cs, expLen);
    for (int i = 0; i < expLen; i++)
      if (i < capCnt[w] - cs)
        checkOutput("byte", 32'(capMem[w][(cs + i) % 64]), 32'(expBytes[i]));
    expCount[w] = (expCount[w] + 1) % 256;
    checkOutput("frameCount", 32'(frameCount[w]), expCount[w]);
    checkOutput("busyIdle", 32'(busyO[w]), 0);
    checkOutput("protocol", protoErr[w], 0);
  endtask

  task automatic runFrame(input int w, input logic [29:0] slots, input int lat, input bit spam);
    int cs, ds;
    busyLen[w] = lat;
    modelFrame(slots, (w == 0));
    cs = capCnt[w];
    ds = doneCnt[w];
    applyStimulus(w, slots);
    checkOutput("acceptBusy", 32'(busyO[w]), 1);
    finishFrame(w, cs, ds, spam);
  endtask

  initial begin
    repeat (3) tick();
    checkOutput("rstStart", 32'(txStart[0]), 0);
    checkOutput("rstData", 32'(txData[0]), 0);
    checkOutput("rstBusy", 32'(busyO[0]), 0);
    checkOutput("rstDone", 32'(frameDone[0]), 0);
    checkOutput("rstCount", 32'(frameCount[0]), 0);
    checkOutput("rstCountB", 32'(frameCount[1]), 0);
    rst = 1'b0;
    tick();
    checkOutput("idleBusy", 32'(busyO[0]), 0);

    // Basic frame with first-byte latency.
    busyLen[0] = 10;
    modelFrame(BASIC, 1'b1);
    c0 = capCnt[0];
    d0 = doneCnt[0];
    applyStimulus(0, BASIC);
    checkOutput("acceptBusy", 32'(busyO[0]), 1);
    checkOutput("noEarlyStart", 32'(txStart[0]), 0);
    tick();
    checkOutput("noEarlyStart", 32'(txStart[0]), 0);
    tick();
    checkOutput("firstStart", 32'(txStart[0]), 1);
    checkOutput("firstByte", 32'(txData[0]), 32'h31);
    finishFrame(0, c0, d0, 1'b0);
    checkOutput("txDataHold", 32'(txData[0]), 32'h0A);

    runFrame(0, SKIPS, 10, 1'b0);
    runFrame(0, BLANKS, 3, 1'b0);
    runFrame(1, BLANKS, 3, 1'b0);

    // Handshake stall before the first byte, with ignored requests during the frame.
    stall[0]   = 1'b1;
    busyLen[0] = 4;
    modelFrame(BASIC, 1'b1);
    c0 = capCnt[0];
    d0 = doneCnt[0];
    applyStimulus(0, BASIC);
    checkOutput("stallAccept", 32'(busyO[0]), 1);
    for (int i = 0; i < 15; i++) begin
      sendReq[0] = (i % 4 == 0);
      tick();
    end
    sendReq[0] = 1'b0;
    checkOutput("stallHold", capCnt[0] - c0, 0);
    checkOutput("stallNoStart", 32'(txStart[0]), 0);
    stall[0] = 1'b0;
    tick();
    checkOutput("stallRelease", 32'(txStart[0]), 1);
    finishFrame(0, c0, d0, 1'b1);
    repeat (20) tick();
    checkOutput("noQueue", doneCnt[0] - d0, 1);
    checkOutput("noQueueBusy", 32'(busyO[0]), 0);

    for (int i = 0; i < 24; i++)
      runFrame(0, randSlots(), int'($urandom_range(1, 12)), 1'b1);

    // The no-terminator instance already completed one frame; 255 more wrap its count to zero.
    for (int i = 0; i < 255; i++)
      runFrame(1, randSlots(), int'($urandom_range(1, 3)), 1'b0);
    checkOutput("wrap", 32'(frameCount[1]), 0);

    // Reset after the second byte of a frame.
    busyLen[0] = 10;
    c0 = capCnt[0];
    applyStimulus(0, BASIC);
    cyc = 0;
    while (capCnt[0] - c0 < 2 && cyc < 500) begin
      tick();
      cyc++;
    end
    checkOutput("reachSecond", capCnt[0] - c0, 2);
    rst = 1'b1;
    #1;
    checkOutput("midRstStart", 32'(txStart[0]), 0);
    checkOutput("midRstData", 32'(txData[0]), 0);
    checkOutput("midRstBusy", 32'(busyO[0]), 0);
    checkOutput("midRstDone", 32'(frameDone[0]), 0);
    checkOutput("midRstCount", 32'(frameCount[0]), 0);
    repeat (2) tick();
    rst = 1'b0;
    expCount[0] = 0;
    expCount[1] = 0;
    repeat (30) tick();
    checkOutput("noStartAfterRst", capCnt[0] - c0, 2);
    checkOutput("idleAfterRst", 32'(busyO[0]), 0);
    runFrame(0, AFTER, 5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
